// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: op codes and FSM states.
package mem_pkg;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_LDR  = 2'b01;
   localparam logic [1:0] OP_STR  = 2'b10;
   localparam logic [1:0] OP_SWP  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_t;

   // True for ops that need the old array word
   function automatic logic op_reads(input logic [1:0] op);
      return (op == OP_LDR) || (op == OP_SWP);
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory-stage control FSM and the responder.
interface data_mem_responder_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with a registered read port; contents are never reset.
module data_mem_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      rdata <= r_mem[addr];
   end
endmodule

// File: rtl/data_mem_responder.sv
// Load/store/swap responder: one request at a time, swap is an atomic read-then-write.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   data_mem_responder_if.slave   bus
);

   state_t            r_state;
   state_t            w_state_d;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rd_buf;
   logic [DATA_W-1:0] r_resp_rdata;
   logic              r_resp_err;
   logic              r_req_ready;
   logic              r_resp_valid;

   logic              w_capture;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_rdata;
   logic              w_resp_load;
   logic [DATA_W-1:0] w_resp_rdata_d;
   logic              w_resp_err_d;

   // The registered read must launch on the acceptance edge so READ sees the word
   assign w_ram_addr = (r_state == IDLE) ? bus.req_addr : r_addr;

   data_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (w_ram_we),
      .addr  (w_ram_addr),
      .wdata (r_wdata),
      .rdata (w_ram_rdata)
   );

   // Next-state, array write enable and response load
   always_comb begin
      w_state_d      = r_state;
      w_capture      = 1'b0;
      w_ram_we       = 1'b0;
      w_resp_load    = 1'b0;
      w_resp_rdata_d = '0;
      w_resp_err_d   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_capture = 1'b1;
               if (op_reads(bus.req_op)) begin
                  w_state_d = READ;
               end else if (bus.req_op == OP_STR) begin
                  w_state_d = WRITE;
               end else begin
                  w_state_d    = RESP;
                  w_resp_load  = 1'b1;
                  w_resp_err_d = 1'b1;
               end
            end
         end
         READ: begin
            if (r_op == OP_SWP) begin
               w_state_d = WRITE;
            end else begin
               w_state_d      = RESP;
               w_resp_load    = 1'b1;
               w_resp_rdata_d = w_ram_rdata;
            end
         end
         WRITE: begin
            w_ram_we       = 1'b1;
            w_state_d      = RESP;
            w_resp_load    = 1'b1;
            w_resp_rdata_d = (r_op == OP_SWP) ? r_rd_buf : '0;
         end
         RESP: begin
            if (bus.resp_ready) begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_op         <= OP_NONE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rd_buf     <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_req_ready  <= (w_state_d == IDLE);
         r_resp_valid <= (w_state_d == RESP);
         if (w_capture) begin
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
         end
         if (r_state == READ) begin
            r_rd_buf <= w_ram_rdata;
         end
         if (w_resp_load) begin
            r_resp_rdata <= w_resp_rdata_d;
            r_resp_err   <= w_resp_err_d;
         end
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = r_resp_err;

endmodule
